// File: rtl/xor_seq_pkg.sv
// Shared types and constants for the XOR gate stimulus/check sequencer.
package xor_seq_pkg;

    localparam int VEC_W   = 2;
    localparam int NUM_VEC = 4;
    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SAMPLE,
        DONE
    } seq_state_t;

endpackage

// File: rtl/xor_seq_hold_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module xor_seq_hold_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/xor_vector_seq.sv
// Clocked stimulus-and-check sequencer for a 2-input XOR gate.
// Optional first-mismatch capture port enabled by XOR_VECTOR_SEQ_FAILCAP_EN.
module xor_vector_seq
    import xor_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 10,
    parameter int N_PASSES    = 1,
    parameter int ERR_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             y_in,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass_ok,
    output logic [ERR_W-1:0] err_cnt
`ifdef XOR_VECTOR_SEQ_FAILCAP_EN
    ,
    output logic [2:0]       first_fail
`endif
);

    localparam logic [7:0]       HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [15:0]      PASS_LAST = 16'(N_PASSES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

    seq_state_t       state_q, state_d;
    logic [VEC_W-1:0] vec_q;
    logic [VEC_W-1:0] vec_next;
    logic [15:0]      pass_cnt;
    logic             start_run;
    logic             advance;
    logic             new_pass;
    logic             mismatch;
    logic             hold_tc;

    assign vec_next = vec_q + 1'b1;

    xor_seq_hold_timer #(
        .CNT_W(8)
    ) u_hold_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (start_run | advance),
        .en      (state_q == APPLY),
        .load_val(HOLD_LOAD),
        .tc      (hold_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A start seen in DONE only counts once done is visible, so busy fully gates restarts.
    always_comb begin
        state_d   = state_q;
        start_run = 1'b0;
        advance   = 1'b0;
        new_pass  = 1'b0;
        mismatch  = (y_in !== (a ^ b));
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_run = 1'b1;
                    state_d   = APPLY;
                end
            end
            APPLY: begin
                if (hold_tc) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (vec_q != LAST_VEC) begin
                    advance = 1'b1;
                    state_d = APPLY;
                end else if (pass_cnt < PASS_LAST) begin
                    advance  = 1'b1;
                    new_pass = 1'b1;
                    state_d  = APPLY;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start && done) begin
                    start_run = 1'b1;
                    state_d   = APPLY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q    <= '0;
            pass_cnt <= '0;
            a        <= 1'b0;
            b        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass_ok  <= 1'b0;
            err_cnt  <= '0;
        end else begin
            if (start_run) begin
                vec_q    <= '0;
                pass_cnt <= '0;
                a        <= 1'b0;
                b        <= 1'b0;
                busy     <= 1'b1;
                done     <= 1'b0;
                pass_ok  <= 1'b0;
                err_cnt  <= '0;
            end else if (advance) begin
                vec_q <= vec_next;
                a     <= vec_next[1];
                b     <= vec_next[0];
                if (new_pass) begin
                    pass_cnt <= pass_cnt + 1'b1;
                end
            end
            if (state_q == SAMPLE && mismatch && err_cnt != ERR_MAX) begin
                err_cnt <= err_cnt + 1'b1;
            end
            // Status is published one cycle after entering DONE, once the last count has landed.
            if (state_q == DONE && busy) begin
                busy    <= 1'b0;
                done    <= 1'b1;
                pass_ok <= (err_cnt == '0);
            end
        end
    end

`ifdef XOR_VECTOR_SEQ_FAILCAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail <= '0;
        end else if (start_run) begin
            first_fail <= '0;
        end else if (state_q == SAMPLE && mismatch && !first_fail[2]) begin
            first_fail <= {1'b1, vec_q};
        end
    end
`endif

endmodule

// File: tb/tb_xor_vector_seq.sv
// Directed self-checking bench for xor_vector_seq (single-pass and five-pass instances).
module tb_xor_vector_seq;

    logic       clk;
    logic       rst_n;
    logic       start_a, start_b;
    logic       y_a, y_b;
    logic       a_a, b_a, busy_a, done_a, pass_a;
    logic       a_b, b_b, busy_b, done_b, pass_b;
    logic [3:0] err_a, err_b;
`ifdef XOR_VECTOR_SEQ_FAILCAP_EN
    logic [2:0] ff_a, ff_b;
`endif

    int   mode_a, mode_b;
    logic x_level;
    int   checks, fails;
    int   cycles;
    logic [1:0] trace [0:63];

    xor_vector_seq #(.HOLD_CYCLES(2), .N_PASSES(1), .ERR_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .y_in(y_a),
        .a(a_a), .b(b_a), .busy(busy_a), .done(done_a), .pass_ok(pass_a),
        .err_cnt(err_a)
`ifdef XOR_VECTOR_SEQ_FAILCAP_EN
        , .first_fail(ff_a)
`endif
    );

    xor_vector_seq #(.HOLD_CYCLES(2), .N_PASSES(5), .ERR_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .y_in(y_b),
        .a(a_b), .b(b_b), .busy(busy_b), .done(done_b), .pass_ok(pass_b),
        .err_cnt(err_b)
`ifdef XOR_VECTOR_SEQ_FAILCAP_EN
        , .first_fail(ff_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate models: 0 real XOR, 1 stuck-at-0, 2 inverted, 3 unknown level during vector 01.
    always_comb begin
        case (mode_a)
            1:       y_a = 1'b0;
            2:       y_a = ~(a_a ^ b_a);
            3:       y_a = ({a_a, b_a} == 2'b01) ? x_level : (a_a ^ b_a);
            default: y_a = a_a ^ b_a;
        endcase
        case (mode_b)
            1:       y_b = 1'b0;
            2:       y_b = ~(a_b ^ b_b);
            default: y_b = a_b ^ b_b;
        endcase
    end

    function automatic logic [1:0] obs_ab(input int sel);
        return (sel == 1) ? {a_b, b_b} : {a_a, b_a};
    endfunction

    function automatic logic obs_done(input int sel);
        return (sel == 1) ? done_b : done_a;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int sel);
        @(negedge clk);
        if (sel == 1) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic waitDone(input int sel, input int mid_start, output int n);
        n = 0;
        trace[0] = obs_ab(sel);
        while (!obs_done(sel) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (n < 64) trace[n] = obs_ab(sel);
            if (sel == 1) start_b = (n == mid_start); else start_a = (n == mid_start);
        end
        start_a = 1'b0;
        start_b = 1'b0;
        if (n >= 2000) checkOutput("done_timeout", n, 0);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_ab_a"},   int'({a_a, b_a}), 0);
        checkOutput({tag, "_busy_a"}, int'(busy_a), 0);
        checkOutput({tag, "_done_a"}, int'(done_a), 0);
        checkOutput({tag, "_pass_a"}, int'(pass_a), 0);
        checkOutput({tag, "_err_a"},  int'(err_a), 0);
        checkOutput({tag, "_busy_b"}, int'(busy_b), 0);
        checkOutput({tag, "_err_b"},  int'(err_b), 0);
`ifdef XOR_VECTOR_SEQ_FAILCAP_EN
        checkOutput({tag, "_ff_a"},   int'(ff_a), 0);
`endif
    endtask

    initial begin
        checks  = 0;
        fails   = 0;
        start_a = 1'b0;
        start_b = 1'b0;
        mode_a  = 0;
        mode_b  = 0;
        x_level = 1'bx;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkReset("reset");
        rst_n = 1'b1;

        // Clean sweep: 00,01,10,11 each held three cycles, done 13 cycles after start.
        applyStimulus(0);
        waitDone(0, -1, cycles);
        checkOutput("t1_cycles", cycles, 13);
        checkOutput("t1_vec0", int'(trace[0]), 0);
        checkOutput("t1_vec0_hold", int'(trace[2]), 0);
        checkOutput("t1_vec1", int'(trace[3]), 1);
        checkOutput("t1_vec2", int'(trace[6]), 2);
        checkOutput("t1_vec3", int'(trace[9]), 3);
        checkOutput("t1_err", int'(err_a), 0);
        checkOutput("t1_pass", int'(pass_a), 1);
        checkOutput("t1_busy", int'(busy_a), 0);
        checkOutput("t1_ab_last", int'({a_a, b_a}), 3);

        // Stuck-at-0 output: vectors 01 and 10 mismatch.
        mode_a = 1;
        applyStimulus(0);
        waitDone(0, -1, cycles);
        checkOutput("t2_cycles", cycles, 13);
        checkOutput("t2_err", int'(err_a), 2);
        checkOutput("t2_pass", int'(pass_a), 0);
`ifdef XOR_VECTOR_SEQ_FAILCAP_EN
        checkOutput("t2_first_fail", int'(ff_a), 5);
`endif

        // Restart from DONE clears status at once; unknown level during vector 01.
        mode_a = 3;
        applyStimulus(0);
        checkOutput("t6_restart_done", int'(done_a), 0);
        checkOutput("t6_restart_err", int'(err_a), 0);
        checkOutput("t6_restart_busy", int'(busy_a), 1);
        checkOutput("t6_restart_ab", int'({a_a, b_a}), 0);
        waitDone(0, -1, cycles);
        checkOutput("t6_cycles", cycles, 13);
        checkOutput("t6_err", int'(err_a), (x_level !== 1'b1) ? 1 : 0);

        // Inverted gate over five passes: 20 mismatches saturate at 15.
        mode_b = 2;
        applyStimulus(1);
        waitDone(1, -1, cycles);
        checkOutput("t3_cycles", cycles, 61);
        checkOutput("t3_err", int'(err_b), 15);
        checkOutput("t3_pass", int'(pass_b), 0);

        // Asynchronous reset during vector 10, then a clean run.
        mode_a = 0;
        applyStimulus(0);
        cycles = 0;
        while ({a_a, b_a} != 2'b10 && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("t4_reached_vec2", int'({a_a, b_a}), 2);
        #2 rst_n = 1'b0;
        #1;
        checkReset("t4_async");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0);
        waitDone(0, -1, cycles);
        checkOutput("t4_cycles", cycles, 13);
        checkOutput("t4_err", int'(err_a), 0);
        checkOutput("t4_pass", int'(pass_a), 1);

        // A start pulse while busy has no effect on timing or counters.
        applyStimulus(0);
        waitDone(0, 5, cycles);
        checkOutput("t5_cycles", cycles, 13);
        checkOutput("t5_err", int'(err_a), 0);
        checkOutput("t5_pass", int'(pass_a), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
